updown_counter_n: RTL and testbench
===================================

UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 Parameter STEP_W, default 3, width of the step input (legal 1..WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  count enable; hold when 0.
REQ-006 down  input  1  direction: 0 = up, 1 = down.
REQ-007 step  input  STEP_W  unsigned increment/decrement magnitude per enabled cycle.
REQ-008 mode  input  1  boundary mode: 0 = wrap (modulo), 1 = saturate.
REQ-009 limit  input  WIDTH  inclusive upper bound; count range is 0..limit.
REQ-010 load  input  1  synchronous parallel load strobe.
REQ-011 load_val  input  WIDTH  value taken on load.
REQ-012 clr_ovf  input  1  clears the sticky overflow flag.
REQ-013 out  output  WIDTH  registered count value.
REQ-014 tc  output  1  registered one-cycle boundary pulse, aligned with the out value produced by the crossing.
REQ-015 ovf  output  1  sticky boundary flag.

Function
REQ-016 Priority per edge: reset, then load, then enabled count, else hold.
REQ-017 Load: out <= min(load_val, limit); tc <= 0; ovf unaffected by load.
REQ-018 en=1, step=0: out holds, tc <= 0.
REQ-019 Effective step s = min(step, limit+1), computed in WIDTH+1 bits; the limit = 2^WIDTH-1 case needs no special handling.
REQ-020 Up, out+s <= limit: out <= out+s, tc <= 0.
REQ-021 Up, out+s > limit: wrap -> out <= out+s-(limit+1); saturate -> out <= limit; tc <= 1.
REQ-022 Down, s <= out: out <= out-s, tc <= 0.
REQ-023 Down, s > out: wrap -> out <= out+(limit+1)-s; saturate -> out <= 0; tc <= 1.
REQ-024 Saturate mode already at bound (out=limit up, or out=0 down) with s>0: out holds, tc <= 1 every such cycle.
REQ-025 Enabled cycle with out > limit (limit lowered at runtime): out <= limit (saturate) or 0 (wrap) regardless of direction, tc <= 1.
REQ-026 limit=0: out stays 0; any enabled cycle with s>0 gives tc=1.
REQ-027 ovf <= 1 on any cycle where tc is set; clr_ovf=1 clears it; simultaneous set and clear -> ovf=1.
REQ-028 down, mode, step and limit may change every cycle; each takes effect on the edge it is sampled at, with no extra latency.
REQ-029 Latency: one clock from inputs to out/tc/ovf; no combinational input-to-output path.

Reset
REQ-030 nrst=0 at a rising edge: out=0, tc=0, ovf=0, regardless of load/en.
REQ-031 Reset asserted mid-count takes effect at that edge; counting resumes from 0 on the first edge with nrst=1.

Structure
REQ-032 Shared package counter_pkg holds mode enum (MODE_WRAP=0, MODE_SAT=1) and direction constants (DIR_UP=0, DIR_DOWN=1).
REQ-033 Single combinational sub-module cnt_next computes next value and boundary flag from out, s, down, mode, limit; top holds registers, load and ovf logic.

Verification
REQ-034 WIDTH=4, limit=15, wrap, up, step=1 from 0, 16 cycles -> out 1..15,0; tc=1 only with out=0; ovf=1 after.
REQ-035 WIDTH=4, limit=9, wrap, up, step=3 from 8 -> out 1 with tc=1; then down, step=2 from 1 -> out 9 with tc=1.
REQ-036 WIDTH=8, limit=200, saturate, up, step=7 from 196 -> out 200, tc=1; held en -> out 200, tc=1 each cycle; down, step=7 -> out 193, tc=0.
REQ-037 load_val=250 with limit=100 -> out 100; limit lowered to 50 then en, saturate -> out 50, tc=1; wrap -> out 0, tc=1.
REQ-038 clr_ovf and tc-producing count on same edge -> ovf=1; clr_ovf alone next edge -> ovf=0.
REQ-039 nrst=0 with load=1, en=1 mid-count at out=123 -> next edge out=0, tc=0, ovf=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter slice.
package counter_pkg;

   // Boundary behaviour when a step crosses 0 or limit.
   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   // Direction encoding of the down input.
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage : counter_pkg

// File: rtl/cnt_next.sv
// Combinational next-count and boundary-crossing calculation.
module cnt_next
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH:0]   s,
   input  logic             down,
   input  logic             mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] nxt_c,
   output logic             bnd_c
);

   localparam int unsigned XW = WIDTH + 1;

   logic [XW-1:0] cur_x;
   logic [XW-1:0] lim_x;
   logic [XW-1:0] lim1_x;
   logic [XW-1:0] sum_x;
   logic          sat;

   // Extended operands so limit+1 and out+s never overflow.
   always_comb begin
      cur_x  = XW'(cur);
      lim_x  = XW'(limit);
      lim1_x = lim_x + XW'(1);
      sum_x  = cur_x + s;
      sat    = (mode_e'(mode) == MODE_SAT);
   end

   // Next value: out-of-range recovery first, then down/up step with wrap or saturate.
   always_comb begin
      nxt_c = cur;
      bnd_c = 1'b0;
      if (s == '0) begin
         nxt_c = cur;
      end else if (cur_x > lim_x) begin
         nxt_c = sat ? limit : '0;
         bnd_c = 1'b1;
      end else if (down == DIR_DOWN) begin
         if (s <= cur_x) begin
            nxt_c = WIDTH'(cur_x - s);
         end else begin
            nxt_c = sat ? '0 : WIDTH'(cur_x + lim1_x - s);
            bnd_c = 1'b1;
         end
      end else begin
         if (sum_x <= lim_x) begin
            nxt_c = WIDTH'(sum_x);
         end else begin
            nxt_c = sat ? limit : WIDTH'(sum_x - lim1_x);
            bnd_c = 1'b1;
         end
      end
   end

endmodule : cnt_next

// File: rtl/updown_counter_n.sv
// Up/down counter with variable step, runtime limit, wrap/saturate and sticky overflow.
module updown_counter_n
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              en,
   input  logic              down,
   input  logic [STEP_W-1:0] step,
   input  logic              mode,
   input  logic [WIDTH-1:0]  limit,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  out,
   output logic              tc,
   output logic              ovf
);

   localparam int unsigned XW = WIDTH + 1;

   logic [XW-1:0]    step_x;
   logic [XW-1:0]    lim1_x;
   logic [XW-1:0]    s;
   logic [WIDTH-1:0] nxt_c;
   logic             bnd_c;
   logic [WIDTH-1:0] out_d;
   logic             tc_d;

   // Effective step clipped to limit+1 so one step never spans more than a full range.
   always_comb begin
      step_x = XW'(step);
      lim1_x = XW'(limit) + XW'(1);
      s      = (step_x > lim1_x) ? lim1_x : step_x;
   end

   cnt_next #(
      .WIDTH (WIDTH)
   ) u_cnt_next (
      .cur   (out),
      .s     (s),
      .down  (down),
      .mode  (mode),
      .limit (limit),
      .nxt_c (nxt_c),
      .bnd_c (bnd_c)
   );

   // Load beats count; a load is clipped to limit and never pulses tc.
   always_comb begin
      out_d = out;
      tc_d  = 1'b0;
      if (load) begin
         out_d = (load_val > limit) ? limit : load_val;
      end else if (en) begin
         out_d = nxt_c;
         tc_d  = bnd_c;
      end
   end

   // State registers; ovf set wins over clear.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         out <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         out <= out_d;
         tc  <= tc_d;
         if (tc_d) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule : updown_counter_n

// File: tb/tb_updown_counter_n.sv
// Directed bench: one WIDTH=4 and one WIDTH=8 counter sharing control inputs.
module tb_updown_counter_n;

   logic       clk = 1'b0;
   logic       nrst;
   logic       en;
   logic       down;
   logic [2:0] step;
   logic       mode;
   logic       load;
   logic       clr_ovf;
   logic [3:0] limit4;
   logic [3:0] lval4;
   logic [7:0] limit8;
   logic [7:0] lval8;
   logic [3:0] out4;
   logic       tc4;
   logic       ovf4;
   logic [7:0] out8;
   logic       tc8;
   logic       ovf8;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   updown_counter_n #(.WIDTH(4), .STEP_W(3)) u_w4 (
      .clk (clk), .nrst (nrst), .en (en), .down (down), .step (step),
      .mode (mode), .limit (limit4), .load (load), .load_val (lval4),
      .clr_ovf (clr_ovf), .out (out4), .tc (tc4), .ovf (ovf4)
   );

   updown_counter_n #(.WIDTH(8), .STEP_W(3)) u_w8 (
      .clk (clk), .nrst (nrst), .en (en), .down (down), .step (step),
      .mode (mode), .limit (limit8), .load (load), .load_val (lval8),
      .clr_ovf (clr_ovf), .out (out8), .tc (tc8), .ovf (ovf8)
   );

   // Count one comparison and report a mismatch.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nrst = 1'b0; en = 1'b0; down = 1'b0; step = 3'd0; mode = 1'b0;
      load = 1'b0; clr_ovf = 1'b0;
      limit4 = 4'd15; lval4 = 4'd0; limit8 = 8'd200; lval8 = 8'd0;
      tick();
      chk("rst_out4", 32'(out4), 0);
      chk("rst_tc4",  32'(tc4),  0);
      chk("rst_ovf4", 32'(ovf4), 0);
      chk("rst_out8", 32'(out8), 0);

      // Full wrap at limit=15, step 1.
      nrst = 1'b1; en = 1'b1; step = 3'd1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("wrap16_out", 32'(out4), 32'((i + 1) % 16));
         chk("wrap16_tc",  32'(tc4),  (i == 15) ? 1 : 0);
         chk("wrap16_ovf", 32'(ovf4), (i == 15) ? 1 : 0);
      end

      // Wrap up then down at limit=9.
      en = 1'b0; load = 1'b1; limit4 = 4'd9; lval4 = 4'd8;
      tick();
      chk("l9_load", 32'(out4), 8);
      load = 1'b0; en = 1'b1; step = 3'd3;
      tick();
      chk("l9_up_out", 32'(out4), 1);
      chk("l9_up_tc",  32'(tc4),  1);
      down = 1'b1; step = 3'd2;
      tick();
      chk("l9_dn_out", 32'(out4), 9);
      chk("l9_dn_tc",  32'(tc4),  1);

      // Hold with en=0, and en=1 with step=0.
      en = 1'b0;
      tick();
      chk("hold_out", 32'(out4), 9);
      chk("hold_tc",  32'(tc4),  0);
      en = 1'b1; step = 3'd0;
      tick();
      chk("step0_out", 32'(out4), 9);
      chk("step0_tc",  32'(tc4),  0);

      // limit=0: load clipped to 0, enabled step pulses tc.
      en = 1'b0; load = 1'b1; limit4 = 4'd0; lval4 = 4'd5;
      tick();
      chk("lim0_load", 32'(out4), 0);
      load = 1'b0; en = 1'b1; down = 1'b0; step = 3'd3;
      tick();
      chk("lim0_out", 32'(out4), 0);
      chk("lim0_tc",  32'(tc4),  1);

      // Saturate at limit=200.
      en = 1'b0; load = 1'b1; limit8 = 8'd200; lval8 = 8'd196; mode = 1'b1;
      tick();
      chk("sat_load", 32'(out8), 196);
      load = 1'b0; en = 1'b1; down = 1'b0; step = 3'd7;
      tick();
      chk("sat_up_out", 32'(out8), 200);
      chk("sat_up_tc",  32'(tc8),  1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("sat_hold_out", 32'(out8), 200);
         chk("sat_hold_tc",  32'(tc8),  1);
      end
      down = 1'b1;
      tick();
      chk("sat_dn_out", 32'(out8), 193);
      chk("sat_dn_tc",  32'(tc8),  0);

      // Load clip and runtime-lowered limit.
      en = 1'b0; load = 1'b1; limit8 = 8'd100; lval8 = 8'd250;
      tick();
      chk("clip_load", 32'(out8), 100);
      load = 1'b0; limit8 = 8'd50; en = 1'b1; mode = 1'b1; down = 1'b0; step = 3'd1;
      tick();
      chk("low_sat_out", 32'(out8), 50);
      chk("low_sat_tc",  32'(tc8),  1);
      en = 1'b0; load = 1'b1; limit8 = 8'd100; lval8 = 8'd100;
      tick();
      chk("relo_load", 32'(out8), 100);
      load = 1'b0; limit8 = 8'd50; en = 1'b1; mode = 1'b0; down = 1'b1;
      tick();
      chk("low_wrap_out", 32'(out8), 0);
      chk("low_wrap_tc",  32'(tc8),  1);

      // Sticky ovf: clear alone, then set+clear together, then clear alone.
      en = 1'b0; clr_ovf = 1'b1;
      tick();
      chk("clr_ovf", 32'(ovf8), 0);
      limit8 = 8'd200; mode = 1'b1; down = 1'b1; step = 3'd1; en = 1'b1;
      tick();
      chk("setclr_out", 32'(out8), 0);
      chk("setclr_tc",  32'(tc8),  1);
      chk("setclr_ovf", 32'(ovf8), 1);
      en = 1'b0;
      tick();
      chk("clr2_ovf", 32'(ovf8), 0);
      chk("clr2_tc",  32'(tc8),  0);
      clr_ovf = 1'b0;

      // Reset mid-count overrides load and en.
      load = 1'b1; lval8 = 8'd199;
      tick();
      load = 1'b0; en = 1'b1; down = 1'b0; step = 3'd7;
      tick();
      chk("pre_ovf", 32'(ovf8), 1);
      en = 1'b0; load = 1'b1; lval8 = 8'd120;
      tick();
      load = 1'b0; en = 1'b1; step = 3'd3;
      tick();
      chk("pre_rst_out", 32'(out8), 123);
      nrst = 1'b0; load = 1'b1; lval8 = 8'd77;
      tick();
      chk("mid_rst_out", 32'(out8), 0);
      chk("mid_rst_tc",  32'(tc8),  0);
      chk("mid_rst_ovf", 32'(ovf8), 0);
      nrst = 1'b1; load = 1'b0; step = 3'd1;
      tick();
      chk("resume_out", 32'(out8), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_updown_counter_n
